// File: rtl/sdrd_slideshow_ctrl_if.sv
// Control and frame-buffer bundle between the slideshow sequencer and its
// neighbours (FAT32 read chain, RGB unpacker, display frame memory).
interface sdrd_slideshow_ctrl_if #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 18
);
   logic              SPI_INIT;
   logic              LOAD_REQ;
   logic [IDX_W-1:0]  LOAD_IDX;
   logic              LOAD_ACK;
   logic              LOAD_ERR;
   logic              RGB_WR;
   logic [63:0]       RGB_DATA;
   logic              PAUSE;
   logic              NEXT;
   logic              FB_WE;
   logic [ADDR_W:0]   FB_ADDR;
   logic [63:0]       FB_DATA;
   logic              DISP_BANK;
   logic              SWAP;
   logic              BUSY;
   logic [7:0]        ERR_CNT;

   modport master (
      input  SPI_INIT, LOAD_ACK, LOAD_ERR, RGB_WR, RGB_DATA, PAUSE, NEXT,
      output LOAD_REQ, LOAD_IDX, FB_WE, FB_ADDR, FB_DATA, DISP_BANK, SWAP,
             BUSY, ERR_CNT
   );

   modport slave (
      output SPI_INIT, LOAD_ACK, LOAD_ERR, RGB_WR, RGB_DATA, PAUSE, NEXT,
      input  LOAD_REQ, LOAD_IDX, FB_WE, FB_ADDR, FB_DATA, DISP_BANK, SWAP,
             BUSY, ERR_CNT
   );
endinterface

// File: rtl/sdrd_slideshow_ctrl.sv
// Slideshow sequencer: requests images by index, writes each into the hidden
// half of a double-buffered frame memory, then swaps banks and holds.
module sdrd_slideshow_ctrl #(
   parameter int NUM_IMAGES     = 16,
   parameter int IDX_W          = 4,
   parameter int WORDS_PER_IMG  = 153600,
   parameter int ADDR_W         = 18,
   parameter int HOLD_CYCLES    = 250000000,
   parameter int HOLD_W         = 28,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 CLK,
   input  logic                 RST_X,
   sdrd_slideshow_ctrl_if.master bus
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_IMG - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IMAGES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RECV,
      ST_SWAP,
      ST_HOLD
   } state_t;

   state_t            state_q,     state_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [ADDR_W-1:0] word_cnt_q,  word_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic              disp_bank_q, disp_bank_d;
   logic              swap_q,      swap_d;
   logic              fb_we_q,     fb_we_d;
   logic [ADDR_W:0]   fb_addr_q,   fb_addr_d;
   logic [63:0]       fb_data_q,   fb_data_d;
   logic [7:0]        err_cnt_q,   err_cnt_d;
   logic              skip;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      word_cnt_d  = word_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      disp_bank_d = disp_bank_q;
      swap_d      = 1'b0;
      fb_we_d     = 1'b0;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;
      err_cnt_d   = err_cnt_q;
      skip        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.SPI_INIT) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (bus.LOAD_ERR) begin
               skip = 1'b1;
            end else if (bus.LOAD_ACK) begin
               word_cnt_d = '0;
               tmo_cnt_d  = '0;
               state_d    = ST_RECV;
            end
         end
         ST_RECV: begin
            if (bus.RGB_WR) begin
               fb_we_d    = 1'b1;
               fb_addr_d  = {~disp_bank_q, word_cnt_q};
               fb_data_d  = bus.RGB_DATA;
               word_cnt_d = word_cnt_q + ADDR_W'(1);
               tmo_cnt_d  = '0;
               // A final word coinciding with an error still completes the image.
               if (word_cnt_q == LAST_WORD) state_d = ST_SWAP;
               else if (bus.LOAD_ERR)       skip    = 1'b1;
            end else if (bus.LOAD_ERR || tmo_cnt_q == TMO_LAST) begin
               skip = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         ST_SWAP: begin
            disp_bank_d = ~disp_bank_q;
            swap_d      = 1'b1;
            hold_cnt_d  = HOLD_LOAD;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.NEXT || hold_cnt_q == '0) begin
               idx_d   = next_idx(idx_q);
               state_d = ST_REQ;
            end else if (!bus.PAUSE) begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (skip) begin
         err_cnt_d = sat_inc8(err_cnt_q);
         idx_d     = next_idx(idx_q);
         state_d   = ST_REQ;
      end

      // Losing the card abandons whatever is in flight; the shown image stays.
      if (!bus.SPI_INIT) begin
         state_d     = ST_IDLE;
         fb_we_d     = 1'b0;
         swap_d      = 1'b0;
         disp_bank_d = disp_bank_q;
         idx_d       = idx_q;
         err_cnt_d   = err_cnt_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_X) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         word_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         hold_cnt_q  <= '0;
         disp_bank_q <= 1'b0;
         swap_q      <= 1'b0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         word_cnt_q  <= word_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         disp_bank_q <= disp_bank_d;
         swap_q      <= swap_d;
         fb_we_q     <= fb_we_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.LOAD_REQ  = (state_q == ST_REQ);
   assign bus.LOAD_IDX  = idx_q;
   assign bus.FB_WE     = fb_we_q;
   assign bus.FB_ADDR   = fb_addr_q;
   assign bus.FB_DATA   = fb_data_q;
   assign bus.DISP_BANK = disp_bank_q;
   assign bus.SWAP      = swap_q;
   assign bus.BUSY      = (state_q == ST_REQ) || (state_q == ST_RECV) ||
                          (state_q == ST_SWAP);
   assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_sdrd_slideshow_ctrl.sv
// Scoreboard bench for the slideshow sequencer with shortened image/hold/timeout.
module tb_sdrd_slideshow_ctrl;
   localparam int NUM_IMAGES     = 3;
   localparam int IDX_W          = 4;
   localparam int WORDS_PER_IMG  = 16;
   localparam int ADDR_W         = 18;
   localparam int HOLD_CYCLES    = 10;
   localparam int HOLD_W         = 28;
   localparam int TIMEOUT_CYCLES = 100;

   typedef struct packed {
      logic [ADDR_W:0] addr;
      logic [63:0]     data;
   } wr_t;

   logic CLK = 1'b0;
   logic RST_X;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   we_cnt = 0;
   wr_t  exp_q[$];

   sdrd_slideshow_ctrl_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

   sdrd_slideshow_ctrl #(
      .NUM_IMAGES    (NUM_IMAGES),
      .IDX_W         (IDX_W),
      .WORDS_PER_IMG (WORDS_PER_IMG),
      .ADDR_W        (ADDR_W),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .HOLD_W        (HOLD_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .CLK  (CLK),
      .RST_X(RST_X),
      .bus  (bus.master)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Every frame-buffer write must match the oldest outstanding expected write.
   always @(negedge CLK) begin
      if (bus.FB_WE === 1'b1) begin
         wr_t e;
         we_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("fb_addr", 64'(bus.FB_ADDR), 64'(e.addr));
            chk("fb_data", bus.FB_DATA, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_req(input logic [IDX_W-1:0] exp_idx, input int budget);
      int k = 0;
      while (!bus.LOAD_REQ && k < budget) begin
         tick();
         k++;
      end
      if (!bus.LOAD_REQ) chk("req_timeout", 64'd0, 64'd1);
      else               chk("load_idx", 64'(bus.LOAD_IDX), 64'(exp_idx));
   endtask

   task automatic ack_after3(input logic [IDX_W-1:0] exp_idx);
      repeat (3) tick();
      chk("idx_stable", 64'(bus.LOAD_IDX), 64'(exp_idx));
      bus.LOAD_ACK = 1'b1;
      tick();
      bus.LOAD_ACK = 1'b0;
      chk("req_drop", 64'(bus.LOAD_REQ), 64'd0);
      chk("busy_recv", 64'(bus.BUSY), 64'd1);
   endtask

   task automatic stream(input int n, input int push_n, input logic bank,
                         input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         wr_t w;
         bus.RGB_WR   = 1'b1;
         bus.RGB_DATA = base + 64'(i);
         if (i < push_n) begin
            w.addr = {bank, ADDR_W'(i)};
            w.data = base + 64'(i);
            exp_q.push_back(w);
         end
         tick();
      end
      bus.RGB_WR = 1'b0;
   endtask

   task automatic wait_swap(input logic exp_bank);
      int k = 0;
      while (!bus.SWAP && k < 40) begin
         tick();
         k++;
      end
      if (!bus.SWAP) begin
         chk("swap_timeout", 64'd0, 64'd1);
      end else begin
         chk("disp_bank", 64'(bus.DISP_BANK), 64'(exp_bank));
         chk("busy_hold", 64'(bus.BUSY), 64'd0);
         tick();
         chk("swap_pulse", 64'(bus.SWAP), 64'd0);
      end
   endtask

   task automatic full_load(input logic [IDX_W-1:0] idx, input logic bank,
                            input logic [63:0] base);
      wait_req(idx, 60);
      ack_after3(idx);
      stream(WORDS_PER_IMG, WORDS_PER_IMG, bank, base);
      wait_swap(bank);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      RST_X        = 1'b1;
      bus.SPI_INIT = 1'b0;
      bus.LOAD_ACK = 1'b0;
      bus.LOAD_ERR = 1'b0;
      bus.RGB_WR   = 1'b0;
      bus.RGB_DATA = '0;
      bus.PAUSE    = 1'b0;
      bus.NEXT     = 1'b0;
      tick();
      tick();
      chk("rst_load_req", 64'(bus.LOAD_REQ), 64'd0);
      chk("rst_load_idx", 64'(bus.LOAD_IDX), 64'd0);
      chk("rst_fb_we", 64'(bus.FB_WE), 64'd0);
      chk("rst_fb_addr", 64'(bus.FB_ADDR), 64'd0);
      chk("rst_fb_data", bus.FB_DATA, 64'd0);
      chk("rst_disp_bank", 64'(bus.DISP_BANK), 64'd0);
      chk("rst_swap", 64'(bus.SWAP), 64'd0);
      chk("rst_busy", 64'(bus.BUSY), 64'd0);
      chk("rst_err_cnt", 64'(bus.ERR_CNT), 64'd0);
      RST_X = 1'b0;
      tick();
      tick();
      chk("idle_no_init", 64'(bus.LOAD_REQ), 64'd0);
      bus.SPI_INIT = 1'b1;

      // Four clean loads: index wraps 0,1,2,0 and the write bank alternates.
      full_load(0, 1'b1, 64'h0);
      full_load(1, 1'b0, 64'h1111_0000_0000_0000);
      full_load(2, 1'b1, 64'h2222_0000_0000_0000);
      full_load(0, 1'b0, 64'h3333_0000_0000_0000);

      wait_req(1, 60);
      ack_after3(1);
      stream(5, 5, 1'b1, 64'h4444_0000_0000_0000);
      bus.LOAD_ERR = 1'b1;
      tick();
      bus.LOAD_ERR = 1'b0;
      chk("err_cnt_1", 64'(bus.ERR_CNT), 64'd1);
      chk("err_disp_keep", 64'(bus.DISP_BANK), 64'd0);
      chk("err_req", 64'(bus.LOAD_REQ), 64'd1);
      chk("err_next_idx", 64'(bus.LOAD_IDX), 64'd2);

      ack_after3(2);
      stream(4, 4, 1'b1, 64'h5555_0000_0000_0000);
      repeat (95) tick();
      chk("no_early_tmo", 64'(bus.LOAD_REQ), 64'd0);
      wait_req(0, 20);
      chk("err_cnt_2", 64'(bus.ERR_CNT), 64'd2);
      chk("tmo_disp_keep", 64'(bus.DISP_BANK), 64'd0);

      ack_after3(0);
      stream(WORDS_PER_IMG, WORDS_PER_IMG, 1'b1, 64'h6666_0000_0000_0000);
      wait_swap(1'b1);
      bus.PAUSE = 1'b1;
      repeat (40) tick();
      chk("pause_hold_req", 64'(bus.LOAD_REQ), 64'd0);
      chk("pause_hold_busy", 64'(bus.BUSY), 64'd0);
      bus.NEXT = 1'b1;
      tick();
      bus.NEXT = 1'b0;
      chk("next_req", 64'(bus.LOAD_REQ), 64'd1);
      chk("next_idx", 64'(bus.LOAD_IDX), 64'd1);
      bus.PAUSE = 1'b0;

      ack_after3(1);
      w0 = we_cnt;
      stream(WORDS_PER_IMG + 5, WORDS_PER_IMG, 1'b0, 64'h7777_0000_0000_0000);
      tick();
      chk("overrun_we_cnt", 64'(we_cnt - w0), 64'(WORDS_PER_IMG));
      chk("overrun_disp", 64'(bus.DISP_BANK), 64'd0);
      chk("overrun_busy", 64'(bus.BUSY), 64'd0);

      wait_req(2, 40);
      ack_after3(2);
      stream(5, 5, 1'b1, 64'h8888_0000_0000_0000);
      bus.SPI_INIT = 1'b0;
      bus.RGB_WR   = 1'b1;
      tick();
      chk("abort_req", 64'(bus.LOAD_REQ), 64'd0);
      chk("abort_busy", 64'(bus.BUSY), 64'd0);
      chk("abort_we", 64'(bus.FB_WE), 64'd0);
      repeat (3) tick();
      bus.RGB_WR = 1'b0;
      chk("abort_we_late", 64'(bus.FB_WE), 64'd0);
      chk("abort_disp", 64'(bus.DISP_BANK), 64'd0);
      chk("abort_idx", 64'(bus.LOAD_IDX), 64'd2);
      chk("abort_err", 64'(bus.ERR_CNT), 64'd2);

      bus.SPI_INIT = 1'b1;
      wait_req(2, 10);
      bus.LOAD_ERR = 1'b1;
      tick();
      bus.LOAD_ERR = 1'b0;
      chk("req_err_cnt", 64'(bus.ERR_CNT), 64'd3);
      chk("req_err_idx", 64'(bus.LOAD_IDX), 64'd0);
      chk("req_err_req", 64'(bus.LOAD_REQ), 64'd1);

      repeat (3) tick();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
